// File: rtl/aes_pkg.sv
// aes_pkg: shared types and helpers for the word-serial AES key-schedule engine.
// Holds the word type, FSM state enum, S-box table, xtime, Rcon table and Nr helper.
package aes_pkg;

    typedef logic [31:0] aes_word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DRAIN
    } state_t;

    // FIPS-197 S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Byte b lives at bits [2047-8b -: 8]; 2047-8b is the 11-bit complement of 8b.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] base;
        base = ~{b, 3'b000};
        return SBOX_TBL[base -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [3:0] nr_f(input int key_bits);
        return 4'(key_bits / 32 + 6);
    endfunction

endpackage

// File: rtl/aes_sbox4.sv
// aes_sbox4: SubWord -- four parallel S-box lookups on one 32-bit word.
module aes_sbox4
    import aes_pkg::*;
(
    input  aes_word_t din,
    output aes_word_t dout
);

    assign dout = {sbox(din[31:24]), sbox(din[23:16]), sbox(din[15:8]), sbox(din[7:0])};

endmodule

// File: rtl/aes_key_expand_param.sv
// aes_key_expand_param: word-serial AES-128/192/256 key schedule, one 128-bit
// round key per valid/ready handshake, in round order 0..Nr.
// Optional build macro AES_KEY_EXPAND_RCON_LUT_EN: Rcon comes from a constant
// table indexed by a counter instead of an xtime-updated register.
//
// Handshake: rk/rk_idx are valid while rk_valid=1; a key is consumed on a rising
// edge with rk_valid && rk_ready; rk/rk_idx hold stable and rk_valid stays high
// until consumed, unless rst or kld abandons the stream.
module aes_key_expand_param
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                kld,
    input  logic [KEY_BITS-1:0] key,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [127:0]        rk,
    output logic [3:0]          rk_idx,
    output logic                busy
);

    localparam int         NK      = KEY_BITS / 32;
    localparam logic [3:0] NR      = nr_f(KEY_BITS);
    localparam logic [5:0] LAST_I  = 6'(4 * (NK + 6) + 3);
    localparam logic [2:0] NK_M1   = 3'(NK - 1);
    localparam logic [2:0] PRE_CNT = 3'(NK - 4);

    state_t     state;
    aes_word_t  win [NK];      // w[i-NK] at index 0 .. w[i-1] at index NK-1
    aes_word_t  buffer [4];    // assembly buffer for the next round key
    logic [2:0] buf_cnt;
    logic [5:0] word_i;
    logic [2:0] phase;         // word_i mod NK, kept incrementally
    logic [7:0] rcon;
    logic [255:0] key_ext;
    aes_word_t  sub_in, sub_out, temp, new_word;
    logic       buf_full, accept, xfer, gen;

`ifdef AES_KEY_EXPAND_RCON_LUT_EN
    logic [3:0] rcon_cnt;
    assign rcon = RCON[rcon_cnt];
`else
    logic [7:0] rcon_q;
    assign rcon = rcon_q;
`endif

    // Left-align the key so words 0..7 sit at fixed positions for every key size.
    always_comb begin
        key_ext = '0;
        key_ext[255 -: KEY_BITS] = key;
    end

    assign buf_full = (buf_cnt == 3'd4);
    assign accept   = rk_valid && rk_ready;
    assign xfer     = buf_full && (!rk_valid || rk_ready);
    // Generation stops only when the buffer is full and the output is stalled.
    assign gen      = (state == ST_EXPAND) && (!buf_full || xfer);

    aes_sbox4 u_sbox (
        .din  (sub_in),
        .dout (sub_out)
    );

    // Next schedule word from the window; one S-box serves both Rcon and Nk=8 steps.
    always_comb begin
        sub_in   = (phase == 3'd0) ? {win[NK-1][23:0], win[NK-1][31:24]} : win[NK-1];
        temp     = win[NK-1];
        if (phase == 3'd0) begin
            temp = sub_out ^ {rcon, 24'h0};
        end else if (NK == 8 && phase == 3'd4) begin
            temp = sub_out;
        end
        new_word = win[0] ^ temp;
    end

    // FSM, window, assembly buffer and output register; rst > kld > stall/accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rk_valid <= 1'b0;
            rk       <= '0;
            rk_idx   <= '0;
            busy     <= 1'b0;
            buf_cnt  <= '0;
            word_i   <= '0;
            phase    <= '0;
            for (int k = 0; k < NK; k++) win[k] <= '0;
            for (int k = 0; k < 4; k++) buffer[k] <= '0;
`ifdef AES_KEY_EXPAND_RCON_LUT_EN
            rcon_cnt <= '0;
`else
            rcon_q   <= 8'h01;
`endif
        end else if (kld) begin
            state    <= ST_EXPAND;
            busy     <= 1'b1;
            rk_valid <= 1'b1;
            rk_idx   <= '0;
            rk       <= key_ext[255 -: 128];
            for (int k = 0; k < NK; k++) win[k] <= key_ext[255-32*k -: 32];
            // Key words 4..NK-1 already belong to round 1; slots past NK-4 are don't-care.
            for (int k = 0; k < 4; k++) buffer[k] <= key_ext[127-32*k -: 32];
            buf_cnt  <= PRE_CNT;
            word_i   <= 6'(NK);
            phase    <= '0;
`ifdef AES_KEY_EXPAND_RCON_LUT_EN
            rcon_cnt <= '0;
`else
            rcon_q   <= 8'h01;
`endif
        end else begin
            if (xfer) begin
                rk       <= {buffer[0], buffer[1], buffer[2], buffer[3]};
                rk_valid <= 1'b1;
                if (rk_idx != NR) rk_idx <= rk_idx + 4'd1;
            end else if (accept) begin
                rk_valid <= 1'b0;
            end

            if (xfer) begin
                buf_cnt <= gen ? 3'd1 : 3'd0;
            end else if (gen) begin
                buf_cnt <= buf_cnt + 3'd1;
            end

            if (gen) begin
                buffer[xfer ? 2'd0 : buf_cnt[1:0]] <= new_word;
                for (int k = 0; k < NK - 1; k++) win[k] <= win[k+1];
                win[NK-1] <= new_word;
                phase <= (phase == NK_M1) ? 3'd0 : phase + 3'd1;
                if (word_i == LAST_I) begin
                    state <= ST_DRAIN;
                end else begin
                    word_i <= word_i + 6'd1;
                end
                if (phase == 3'd0) begin
`ifdef AES_KEY_EXPAND_RCON_LUT_EN
                    if (rcon_cnt != 4'd9) rcon_cnt <= rcon_cnt + 4'd1;
`else
                    rcon_q <= xtime(rcon_q);
`endif
                end
            end

            if (state == ST_DRAIN && accept && !xfer && rk_idx == NR) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_key_expand_param.sv
// tb_aes_key_expand_param: directed checks of the AES key-schedule engine for
// 128/192/256-bit keys, backpressure, reload storms and mid-stream reset.
module tb_aes_key_expand_param;

    localparam logic [255:0] K_SEQ  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K_FIPS = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K_ONES = {128'hffffffffffffffffffffffffffffffff, 128'h0};
    localparam logic [255:0] K_192  = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K_256  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rk_ready = 1'b0;
    logic         kld [3];
    logic [127:0] key128 = '0;
    logic [191:0] key192 = '0;
    logic [255:0] key256 = '0;
    logic         rk_valid_s [3];
    logic [127:0] rk_s [3];
    logic [3:0]   idx_s [3];
    logic         busy_s [3];

    int           checks = 0;
    int           failures = 0;
    logic [127:0] exp_q [$];
    logic [127:0] cap [15];
    int           cap_cyc [15];
    logic [31:0]  w_ref [60];
    logic [7:0]   sbox_t [256];

    aes_key_expand_param #(.KEY_BITS(128)) dut128 (
        .clk(clk), .rst(rst), .kld(kld[0]), .key(key128), .rk_valid(rk_valid_s[0]),
        .rk_ready(rk_ready), .rk(rk_s[0]), .rk_idx(idx_s[0]), .busy(busy_s[0]));
    aes_key_expand_param #(.KEY_BITS(192)) dut192 (
        .clk(clk), .rst(rst), .kld(kld[1]), .key(key192), .rk_valid(rk_valid_s[1]),
        .rk_ready(rk_ready), .rk(rk_s[1]), .rk_idx(idx_s[1]), .busy(busy_s[1]));
    aes_key_expand_param #(.KEY_BITS(256)) dut256 (
        .clk(clk), .rst(rst), .kld(kld[2]), .key(key256), .rk_valid(rk_valid_s[2]),
        .rk_ready(rk_ready), .rk(rk_s[2]), .rk_idx(idx_s[2]), .busy(busy_s[2]));

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic apply_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference S-box from first principles: GF(2^8) inverse followed by the affine map.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    // Textbook array-form key expansion into w_ref.
    task automatic ref_expand(input logic [255:0] k, input int nk);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int n = 0; n < nk; n++) w_ref[n] = k[255-32*n -: 32];
        for (int n = nk; n < 4 * (nk + 7); n++) begin
            t = w_ref[n-1];
            if (n % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end else if (nk == 8 && n % nk == 4) begin
                t = sub_word(t);
            end
            w_ref[n] = w_ref[n-nk] ^ t;
        end
    endtask

    // Driver: pulse kld for one edge; called and returns at a falling edge.
    task automatic do_load(input int s, input logic [255:0] k);
        case (s)
            0:       key128 = k[255:128];
            1:       key192 = k[255:64];
            default: key256 = k;
        endcase
        kld[s] = 1'b1;
        @(negedge clk);
        kld[s] = 1'b0;
    endtask

    // Load a key and consume its whole stream, scoreboarding every accepted round key.
    task automatic run_stream(input int s, input logic [255:0] k, input bit rnd, input string tag);
        int           nk;
        int           nr;
        int           cyc;
        int           n_acc;
        bit           stalled;
        logic [131:0] held;
        logic [127:0] e;
        nk = 4 + 2 * s;
        nr = nk + 6;
        cyc = 0;
        n_acc = 0;
        stalled = 1'b0;
        held = '0;
        ref_expand(k, nk);
        for (int r = 0; r <= nr; r++)
            exp_q.push_back({w_ref[4*r], w_ref[4*r+1], w_ref[4*r+2], w_ref[4*r+3]});
        for (int r = 0; r < 15; r++) begin
            cap[r] = '0;
            cap_cyc[r] = -1;
        end
        do_load(s, k);
        check({tag, "_busy_start"}, busy_s[s], 1'b1);
        while (exp_q.size() > 0 && cyc < 600) begin
            if (stalled)
                check({tag, "_hold"}, {rk_valid_s[s], idx_s[s], rk_s[s]}, {1'b1, held});
            rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rk_valid_s[s] && rk_ready) begin
                e = exp_q.pop_front();
                check({tag, "_rk"}, rk_s[s], e);
                check({tag, "_idx"}, idx_s[s], n_acc);
                cap[n_acc] = rk_s[s];
                cap_cyc[n_acc] = cyc;
                n_acc++;
            end
            stalled = rk_valid_s[s] && !rk_ready;
            held = {idx_s[s], rk_s[s]};
            @(negedge clk);
            cyc++;
        end
        check({tag, "_complete"}, exp_q.size(), 0);
        exp_q.delete();
        check({tag, "_busy_end"}, {busy_s[s], rk_valid_s[s]}, 2'b00);
        rk_ready = 1'b1;
    endtask

    initial begin
        logic [255:0] kk;
        int           n;
        kld[0] = 1'b0;
        kld[1] = 1'b0;
        kld[2] = 1'b0;
        build_sbox();
        @(negedge clk);
        apply_reset(2);

        // Reset values
        for (int s = 0; s < 3; s++)
            check("reset_outputs", {rk_valid_s[s], busy_s[s], idx_s[s], rk_s[s]}, '0);

        // AES-128 unstalled: content and timing
        run_stream(0, K_SEQ, 1'b0, "aes128");
        check("aes128_rk0", cap[0], K_SEQ[255:128]);
        check("aes128_rk10", cap[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("aes128_rk1_cyc", cap_cyc[1], 5);
        check("aes128_rk10_cyc", cap_cyc[10], 41);

        // AES-192
        run_stream(1, K_192, 1'b0, "aes192");
        check("aes192_rk12", cap[12], 128'he98ba06f448c773c8ecc720401002202);
        check("aes192_rk12_cyc", cap_cyc[12], 47);

        // AES-256
        run_stream(2, K_256, 1'b0, "aes256");
        check("aes256_rk1", cap[1], 128'h1f352c073b6108d72d9810a30914dff4);
        check("aes256_rk14", cap[14], 128'hfe4890d1e6188d0b046df344706c631e);
        check("aes256_rk1_cyc", cap_cyc[1], 1);
        check("aes256_rk14_cyc", cap_cyc[14], 53);

        // AES-128 with random backpressure
        run_stream(0, K_FIPS, 1'b1, "bp128");
        check("bp128_rk1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("bp128_rk10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Reload storm: kld coinciding with an accept, then loads every 2 cycles
        rk_ready = 1'b1;
        do_load(0, K_SEQ);
        check("storm_first_r0", {rk_valid_s[0], idx_s[0], rk_s[0]}, {1'b1, 4'd0, K_SEQ[255:128]});
        repeat (5) @(negedge clk);
        check("storm_first_r1", {rk_valid_s[0], idx_s[0]}, {1'b1, 4'd1});
        for (int m = 0; m < 3; m++) begin
            kk = (m % 2 == 0) ? K_ONES : '0;
            do_load(0, kk);
            check("storm_load_r0", {rk_valid_s[0], idx_s[0], rk_s[0]}, {1'b1, 4'd0, kk[255:128]});
            @(negedge clk);
            check("storm_no_stale", rk_valid_s[0], 1'b0);
        end
        run_stream(0, '0, 1'b0, "storm_final");
        check("storm_final_rk10", cap[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Reset in the middle of a schedule, then reload
        rk_ready = 1'b1;
        do_load(0, K_FIPS);
        n = 0;
        while (!(rk_valid_s[0] && idx_s[0] == 4'd6) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach_r6", {rk_valid_s[0], idx_s[0], rk_s[0]},
              {1'b1, 4'd6, 128'h6d88a37a110b3efddbf98641ca0093fd});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_zero", {rk_valid_s[0], busy_s[0], idx_s[0], rk_s[0]}, '0);
        run_stream(0, K_FIPS, 1'b0, "after_rst");
        check("after_rst_rk10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("after_rst_rk10_cyc", cap_cyc[10], 41);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_key_expand_param.md
# aes_key_expand_param

Parametrised AES key-schedule engine producing round keys in order, one 128-bit round key per accepted handshake, for AES-128/192/256 (selected by `KEY_BITS`). Sits between the key-load path and the cipher/decipher datapath. Replaces the fixed 128-bit expander with a word-serial generator behind a valid/ready output, so the consumer can stall it. A new key can be loaded at any time.

## Interface
- `KEY_BITS`, 128: key size; legal values 128, 192, 256. Derived: Nk = KEY_BITS/32 (4/6/8), Nr = Nk+6 (10/12/14).
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `kld` input 1: key load strobe; `key` sampled on the same edge.
- `key` input KEY_BITS: cipher key, word 0 in the MSBs (FIPS-197 byte order).
- `rk_valid` output 1: `rk`/`rk_idx` hold a valid round key.
- `rk_ready` input 1: consumer accepts `rk` when high with `rk_valid`.
- `rk` output 128: round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
- `rk_idx` output 4: round number r, 0..Nr.
- `busy` output 1: schedule in progress, from kld accept until final round key accepted.

## Operation
- FSM states: IDLE, EXPAND, DRAIN.
  - IDLE → EXPAND on `kld`.
  - EXPAND → DRAIN once word 4·Nr+3 is generated.
  - DRAIN → IDLE when round Nr is accepted.
  - `kld` in any state restarts from load.
- On load:
  - Nk-word window register takes `key`.
  - Word counter i := Nk.
  - Rcon := 0x01.
  - Assembly buffer is pre-filled with the key words beyond the first round key: none for 128, 2 for 192, 4 for 256.
  - Round key 0 (words 0..3) is written to the output register.
- Word generation, one per cycle while in EXPAND and not stalled:
  - temp = w[i-1].
  - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {Rcon, 24'h0}, then Rcon advances.
  - Else if Nk==8 and i mod 8 == 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp; the window shifts; i increments.
- Assembly buffer:
  - Collects 4 words.
  - When full and the output register is empty, or being accepted this cycle, it transfers to `rk` and `rk_idx` increments.
- Stall: generation halts only when the buffer is full and `rk_valid && !rk_ready`. No word is ever dropped or duplicated.
- Handshake:
  - `rk`/`rk_idx` are held stable while `rk_valid && !rk_ready`.
  - `rk_valid` never drops without acceptance, except on `kld` or `rst`.
- Priority: `rst` > `kld` > stall/accept.
  - A `kld` on the same edge as an accept discards the accepted key's successors.
- S-box: four combinational SubBytes instances, shared between the Rcon and Nk=8 cases.
- Width rules:
  - `rk_idx` saturates at Nr.
  - The word counter is 6 bits; its maximum is 59.

## Timing
- Reset values: `rk_valid`=0, `rk`=0, `rk_idx`=0, `busy`=0, FSM=IDLE, Rcon=0x01.
- `kld` at edge t gives `rk_valid`=1, `rk_idx`=0, `busy`=1 after t.
- AES-128 with `rk_ready` tied high:
  - rk r (r≥1) is valid 4r+1 cycles after the load edge.
  - Last round key at t+41.
  - `busy` falls the cycle after its acceptance.
- AES-192: 46 generated words. AES-256: 52 generated words. Both produce one word per cycle when unstalled.
- `kld` while busy: the previous stream is abandoned with no extra output cycle. The next `rk` is round 0 of the new key.
- `rst` mid-expansion: all outputs take their reset values on the next cycle.

## Configuration
- `AES_KEY_EXPAND_RCON_LUT_EN`:
  - Defined: Rcon is read from a 10-entry constant table indexed by an Rcon counter.
  - Undefined: Rcon is a register updated by GF(2^8) xtime (0x80 → 0x1B).
  - Outputs are cycle-identical in both builds.

## Structure
- Package `aes_pkg`:
  - `aes_word_t` (32-bit).
  - S-box function/table.
  - `xtime` function.
  - `RCON` constant array.
  - `nr_f(KEY_BITS)` function.
  - FSM state enum.
- Sub-module `aes_sbox4`: SubWord on one 32-bit word, combinational, instantiated once.

## Test plan
- AES-128, key 000102030405060708090a0b0c0d0e0f, `rk_ready`=1 → rk0 = key; rk10 = 13111d7fe3944a17f307a78b4d2b30c5 at t+41; `busy` low after.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → 13 round keys; rk12 = e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → rk1 = 1f352c073b6108d72d9810a30914dff4; rk14 = fe4890d1e6188d0b046df344706c631e.
- Random `rk_ready` backpressure (≈50%) with the AES-128 key 2b7e151628aed2a6abf7158809cf4f3c → the accepted sequence equals the unstalled one; rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6; `rk` is stable during stalls.
- `kld` of 000102…0f, then `kld` of the all-ones key after 5 cycles, then alternating all-ones/all-zeros loads every 2 cycles → each reload gives `rk_idx`=0 with that key next cycle; there is no stale round; the final all-zeros key completes with rk10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- `rst` asserted at round 6, then `kld` → outputs zero for one cycle; the fresh schedule matches the reference vectors. Repeat for both `AES_KEY_EXPAND_RCON_LUT_EN` builds.
